fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 45 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Provides the fetch FSM state type, default reset PC, instruction/opcode widths,
// the PC increment and a helper that word-aligns an address.
package mips_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned OP_W             = 6;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // S_REQ:   request active on the memory port
  // S_HOLD:  response parked in the skid buffer while decode is stalled
  // S_DRAIN: redirect seen, waiting for the stale response to be thrown away
  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the fetch stage.
// Holds a response that arrived while IF/ID was full and decode was stalled.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - capture data_in and mark the entry valid
//   clear       - drop the entry (wins over load and pop)
//   pop         - entry consumed; mark invalid
//   data_in     - value to capture
//   data_out    - buffered value
//   valid       - entry is live
module fetch_skid_buf #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             pop,
  input  logic [Width-1:0] data_in,
  output logic [Width-1:0] data_out,
  output logic             valid
);

  logic [Width-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= data_in;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues word-aligned requests to instruction memory, buffers one response when
// decode stalls, and handles redirects including a still-outstanding request.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   ImemReq/ImemAddr    - memory request and word address (held until ack)
//   ImemAck/ImemData    - memory response strobe and instruction word
//   Stall               - decode cannot accept; IF/ID holds
//   Redirect/RedirectPC - flush and refetch from target (low two bits ignored)
//   IfIdValid/IfIdInstr/IfIdPC4 - IF/ID register contents
//   Op                  - opcode field of IfIdInstr
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ImemReq,
  output logic [31:0]        ImemAddr,
  input  logic               ImemAck,
  input  logic [INSTR_W-1:0] ImemData,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [31:0]        RedirectPC,
  output logic               IfIdValid,
  output logic [INSTR_W-1:0] IfIdInstr,
  output logic [31:0]        IfIdPC4,
  output logic [OP_W-1:0]    Op
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        tgt_q, tgt_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [31:0]        ifid_pc4_q, ifid_pc4_d;

  logic [31:0]          pc_plus4;
  logic [31:0]          redirect_tgt;
  logic                 skid_load, skid_clear, skid_pop, skid_valid;
  logic [INSTR_W+31:0]  skid_out;

  assign pc_plus4     = pc_q + PC_INC;  // wraps naturally at 2^32
  assign redirect_tgt = word_align(RedirectPC);

  fetch_skid_buf #(
    .Width (INSTR_W + 32)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .pop      (skid_pop),
    .data_in  ({ImemData, pc_plus4}),
    .data_out (skid_out),
    .valid    (skid_valid)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    skid_pop     = 1'b0;

    case (state_q)
      S_REQ: begin
        if (Redirect) begin
          ifid_valid_d = 1'b0;
          skid_clear   = 1'b0 | 1'b1;
          if (ImemAck) begin
            pc_d = redirect_tgt;
          end else begin
            // Request is in flight; its response must be drained first.
            tgt_d   = redirect_tgt;
            state_d = S_DRAIN;
          end
        end else if (ImemAck) begin
          pc_d = pc_plus4;
          if (!ifid_valid_q || !Stall) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = ImemData;
            ifid_pc4_d   = pc_plus4;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (!Stall) begin
          // Decode consumed the current entry and nothing new arrived.
          ifid_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (Redirect) begin
          ifid_valid_d = 1'b0;
          skid_clear   = 1'b1;
          pc_d         = redirect_tgt;
          state_d      = S_REQ;
        end else if (!Stall && skid_valid) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = skid_out[INSTR_W+31:32];
          ifid_pc4_d   = skid_out[31:0];
          skid_pop     = 1'b1;
          state_d      = S_REQ;
        end
      end

      S_DRAIN: begin
        ifid_valid_d = 1'b0;
        if (ImemAck) begin
          // Stale response is dropped; a same-cycle redirect is the newest target.
          pc_d    = Redirect ? redirect_tgt : tgt_q;
          state_d = S_REQ;
        end else if (Redirect) begin
          tgt_d = redirect_tgt;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  // The request is suppressed while reset is held so nothing is issued mid-reset.
  assign ImemReq   = rst_n && (state_q != S_HOLD);
  assign ImemAddr  = pc_q;
  assign IfIdValid = ifid_valid_q;
  assign IfIdInstr = ifid_instr_q;
  assign IfIdPC4   = ifid_pc4_q;
  assign Op        = ifid_instr_q[INSTR_W-1 -: OP_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle stimulus, a queue of expected
// fetch addresses consumed whenever decode accepts an IF/ID entry.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IfIdValid;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPC4;
  logic [5:0]  Op;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (ImemAck),
    .ImemData   (ImemData),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IfIdValid  (IfIdValid),
    .IfIdInstr  (IfIdInstr),
    .IfIdPC4    (IfIdPC4),
    .Op         (Op)
  );

  always #5 clk = ~clk;

  // Memory contents as a function of address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs shortly after the edge; memory answers from ImemAddr.
  task automatic drive(input logic ack, input logic stall, input logic redir,
                       input logic [31:0] rpc);
    ImemAck    = ack;
    Stall      = stall;
    Redirect   = redir;
    RedirectPC = rpc;
    ImemData   = ack ? word(ImemAddr) : 32'hDEAD_0000;
    #1;
  endtask

  // Scoreboard side: decode accepts or a redirect flushes, then advance a cycle.
  task automatic clock();
    logic [31:0] a;
    logic [31:0] w;
    if (rst_n && Redirect) begin
      exp_q.delete();
    end else if (rst_n && IfIdValid === 1'b1 && !Stall) begin
      n_checks++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_instr: got pc4 %h, expected no live entry", IfIdPC4);
      end
      if (exp_q.size() != 0) begin
        a = exp_q.pop_front();
        w = word(a);
        check("sb_instr", IfIdInstr, w);
        check("sb_pc4", IfIdPC4, a + 32'd4);
        check("sb_op", {26'd0, Op}, {26'd0, w[31:26]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    ImemAck    = 1'b0;
    ImemData   = '0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_req", {31'd0, ImemReq}, 32'd0);
    check("rst_valid", {31'd0, IfIdValid}, 32'd0);
    check("rst_instr", IfIdInstr, 32'd0);
    check("rst_pc4", IfIdPC4, 32'd0);
    check("rst_op", {26'd0, Op}, 32'd0);
    clock();

    // Zero-wait streaming
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("s_req0", {31'd0, ImemReq}, 32'd1);
    check("s_addr0", ImemAddr, 32'h0);
    exp_q.push_back(32'h0); clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("s_addr4", ImemAddr, 32'h4);
    check("s_pc4_4", IfIdPC4, 32'h4);
    check("s_valid", {31'd0, IfIdValid}, 32'd1);
    exp_q.push_back(32'h4); clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("s_addr8", ImemAddr, 32'h8);
    check("s_pc4_8", IfIdPC4, 32'h8);
    exp_q.push_back(32'h8); clock();
    check("s_pc4_12", IfIdPC4, 32'hC);

    // Stall with an ack arriving: response goes to the skid buffer
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("st_addr12", ImemAddr, 32'hC);
    exp_q.push_back(32'hC); clock();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("st_req", {31'd0, ImemReq}, 32'd0);
      check("st_pc4_hold", IfIdPC4, 32'hC);
      check("st_valid_hold", {31'd0, IfIdValid}, 32'd1);
      clock();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("st_req3", {31'd0, ImemReq}, 32'd0);
    clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("st_skid_pc4", IfIdPC4, 32'h10);
    check("st_req_back", {31'd0, ImemReq}, 32'd1);
    check("st_addr16", ImemAddr, 32'h10);
    exp_q.push_back(32'h10); clock();

    // Redirect with same-cycle ack
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    check("rd_addr20", ImemAddr, 32'h14);
    clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rd_valid0", {31'd0, IfIdValid}, 32'd0);
    check("rd_addr40", ImemAddr, 32'h40);
    exp_q.push_back(32'h40); clock();
    check("rd_instr40", IfIdInstr, word(32'h40));
    check("rd_addr44", ImemAddr, 32'h44);

    // Redirect during a memory wait, then a second redirect while draining
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    clock();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    check("dr_addr_hold1", ImemAddr, 32'h44);
    check("dr_req1", {31'd0, ImemReq}, 32'd1);
    check("dr_valid0", {31'd0, IfIdValid}, 32'd0);
    clock();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("dr_addr_hold2", ImemAddr, 32'h44);
    clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("dr_addr_hold3", ImemAddr, 32'h44);
    clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("dr_dropped", {31'd0, IfIdValid}, 32'd0);
    check("dr_addr200", ImemAddr, 32'h200);
    exp_q.push_back(32'h200); clock();
    check("dr_pc4_204", IfIdPC4, 32'h204);

    // Address wrap
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    clock();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("wr_addr", ImemAddr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC); clock();
    check("wr_pc4", IfIdPC4, 32'h0);
    check("wr_addr0", ImemAddr, 32'h0);

    // Reset asserted while holding a buffered response
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h0); clock();
    check("rh_req", {31'd0, ImemReq}, 32'd0);
    check("rh_addr4", ImemAddr, 32'h4);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    clock();
    exp_q.delete();
    check("rh_valid", {31'd0, IfIdValid}, 32'd0);
    check("rh_instr", IfIdInstr, 32'd0);
    check("rh_pc4", IfIdPC4, 32'd0);
    check("rh_req_low", {31'd0, ImemReq}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rh_req_rel", {31'd0, ImemReq}, 32'd1);
    check("rh_addr_reset", ImemAddr, 32'h0);
    exp_q.push_back(32'h0); clock();
    check("rh_pc4_after", IfIdPC4, 32'h4);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    clock();
    check("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
